// File: rtl/adc_pkg.sv
// Shared constants and scan-state encoding for the ADC scan/average slice.
package adc_pkg;
  localparam int unsigned ADC_DATA_W = 10;
  localparam int unsigned ADC_CH_W   = 3;
  localparam int unsigned ADC_MAX_CH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } scan_state_t;
endpackage

// File: rtl/adc_avg_acc.sv
// Per-channel accumulator: sums 2^LOG2_AVG samples, flags the closing sample
// and presents the truncated mean of the full set on that same cycle.
module adc_avg_acc #(
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned LOG2_AVG = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample,
  output logic              publish,
  output logic [DATA_W-1:0] result
);
  localparam int unsigned ACC_W = DATA_W + LOG2_AVG;
  localparam int unsigned CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_AVG) - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] samp_cnt;

  assign publish = sample_en && (samp_cnt == LAST_CNT);
  // The closing sample is folded in combinationally so the mean is ready
  // on the capturing edge rather than one clk later.
  assign result  = DATA_W'((acc + ACC_W'(sample)) >> LOG2_AVG);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      samp_cnt <= '0;
    end else if (clr || publish) begin
      acc      <= '0;
      samp_cnt <= '0;
    end else if (sample_en) begin
      acc      <= acc + ACC_W'(sample);
      samp_cnt <= samp_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/adc_scan_avg.sv
// Round-robin ADC channel scanner: drives the serial ADC interface, averages
// each channel's conversions and streams one averaged word per channel.
module adc_scan_avg
  import adc_pkg::*;
#(
  parameter int unsigned DATA_W   = ADC_DATA_W,
  parameter int unsigned NUM_CH   = ADC_MAX_CH,
  parameter int unsigned LOG2_AVG = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                adc_done,
  input  logic [DATA_W-1:0]   adc_data,
  output logic                adc_enable,
  output logic [ADC_CH_W-1:0] ch_sel,
  output logic                avg_valid,
  output logic [ADC_CH_W-1:0] avg_ch,
  output logic [DATA_W-1:0]   avg_data,
  output logic                frame_done,
  output logic                busy
);
  localparam logic [ADC_CH_W-1:0] LAST_CH = ADC_CH_W'(NUM_CH - 1);

  scan_state_t       state;
  logic              done_q;
  logic              done_rise;
  logic              sample_en;
  logic              acc_clr;
  logic              publish;
  logic [DATA_W-1:0] result;

  assign done_rise = adc_done & ~done_q;
  assign sample_en = (state == RUN) && done_rise;
  assign acc_clr   = (state == IDLE) || !start;

  adc_avg_acc #(
    .DATA_W  (DATA_W),
    .LOG2_AVG(LOG2_AVG)
  ) u_acc (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (acc_clr),
    .sample_en(sample_en),
    .sample   (adc_data),
    .publish  (publish),
    .result   (result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      done_q     <= 1'b0;
      adc_enable <= 1'b0;
      ch_sel     <= '0;
      avg_valid  <= 1'b0;
      avg_ch     <= '0;
      avg_data   <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done_q     <= adc_done;
      avg_valid  <= 1'b0;
      frame_done <= 1'b0;

      if (publish) begin
        avg_data   <= result;
        avg_ch     <= ch_sel;
        avg_valid  <= 1'b1;
        frame_done <= (ch_sel == LAST_CH);
        ch_sel     <= (ch_sel == LAST_CH) ? '0 : ch_sel + ADC_CH_W'(1);
      end

      // A stop on a publishing edge lets the publish land, then forces the
      // channel back to 0 by overriding the advance above.
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            adc_enable <= 1'b1;
            busy       <= 1'b1;
            ch_sel     <= '0;
          end
        end
        RUN: begin
          if (!start) begin
            state      <= IDLE;
            adc_enable <= 1'b0;
            busy       <= 1'b0;
            ch_sel     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
